// File: rtl/keypad_emulator.sv
// 4x4 matrix keypad emulator: answers a column scan on the row lines as if a
// requested key were held for HOLD_SCANS scans and then released for RELEASE_SCANS scans.
module keypad_emulator #(
  parameter int unsigned HOLD_SCANS     = 4,
  parameter int unsigned RELEASE_SCANS  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_code,
  input  logic       press,
  input  logic [3:0] col,
  output logic [3:0] fila,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned MaxScans = (HOLD_SCANS > RELEASE_SCANS) ? HOLD_SCANS : RELEASE_SCANS;
  localparam int unsigned ScanW    = $clog2(MaxScans + 1);
  localparam int unsigned IdleW    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [ScanW-1:0] HoldLast = ScanW'(HOLD_SCANS - 1);
  localparam logic [ScanW-1:0] RelLast  = ScanW'(RELEASE_SCANS - 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSync, StHold, StRelease} state_e;

  state_e           state_q;
  logic [3:0]       col_q;
  logic [3:0]       key_q;
  logic [ScanW-1:0] scan_q;
  logic [IdleW-1:0] idle_q;
  logic             sstart;

  assign sstart = (col == 4'b0001) && (col_q != 4'b0001);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      col_q   <= '0;
      key_q   <= '0;
      scan_q  <= '0;
      idle_q  <= '0;
      done    <= 1'b0;
      error   <= 1'b0;
    end else begin
      col_q <= col;
      done  <= 1'b0;
      error <= 1'b0;
      case (state_q)
        StIdle: begin
          if (press) begin
            key_q   <= key_code;
            scan_q  <= '0;
            idle_q  <= '0;
            state_q <= StSync;
          end
        end
        default: begin
          // A scan start always beats the timeout threshold in the same cycle.
          if (sstart) begin
            idle_q <= '0;
            if (state_q == StSync) begin
              state_q <= StHold;
              scan_q  <= '0;
            end else if (state_q == StHold) begin
              if (scan_q == HoldLast) begin
                state_q <= StRelease;
                scan_q  <= '0;
              end else begin
                scan_q <= scan_q + 1'b1;
              end
            end else begin
              if (scan_q == RelLast) begin
                state_q <= StIdle;
                scan_q  <= '0;
                done    <= 1'b1;
              end else begin
                scan_q <= scan_q + 1'b1;
              end
            end
          end else if (idle_q == IdleLast) begin
            state_q <= StIdle;
            idle_q  <= '0;
            scan_q  <= '0;
            error   <= 1'b1;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign busy = (state_q != StIdle);

  // Zero-latency row answer so the controller sees the key in the same column slot.
  always_comb begin
    fila = '0;
    if ((state_q == StHold) && (col == (4'b0001 << key_q[1:0]))) begin
      fila = 4'b0001 << key_q[3:2];
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: table of full key requests against a 16-cycle column scanner,
// plus hand-written timeout and mid-request reset sequences.
module tb_keypad_emulator;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_code;
  logic       press;
  logic [3:0] col;
  logic [3:0] fila_a, fila_b;
  logic       busy_a, busy_b, done_a, done_b, error_a, error_b;

  keypad_emulator u_dut (
    .clk      (clk),
    .reset    (reset),
    .key_code (key_code),
    .press    (press),
    .col      (col),
    .fila     (fila_a),
    .busy     (busy_a),
    .done     (done_a),
    .error    (error_a)
  );

  keypad_emulator #(
    .TIMEOUT_CYCLES (32)
  ) u_dut_to (
    .clk      (clk),
    .reset    (reset),
    .key_code (key_code),
    .press    (press),
    .col      (col),
    .fila     (fila_b),
    .busy     (busy_b),
    .done     (done_b),
    .error    (error_b)
  );

  always #5 clk = ~clk;

  int         total  = 0;
  int         passed = 0;
  int         ph     = 0;
  bit         freeze = 1'b0;
  logic [3:0] freeze_val = 4'b0100;
  logic [3:0] col_prev = 4'b0000;

  typedef struct {
    logic [3:0] key;
    logic [3:0] exp_fila;
    logic [3:0] exp_col;
    int         exp_hits;
    bit         corrupt;
    bit         interfere;
  } req_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Advance one clock; new inputs are driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    ph++;
    col_prev = col;
    col = freeze ? freeze_val : (4'b0001 << ((ph / 4) % 4));
  endtask

  task automatic run_request(input req_t r, input string tag);
    int first_s = -1;
    int done_k  = -1;
    int hits = 0, bad = 0, errs = 0, busy_gap = 0, late_done = 0, late_busy = 0;
    key_code = r.key;
    press    = 1'b1;
    step();
    press = 1'b0;
    #1;
    check({tag, "_busy_after_press"}, busy_a, 1);
    for (int k = 0; k < 400; k++) begin
      if (k > 0) begin
        step();
        press = 1'b0;
        if (r.corrupt && first_s >= 0 && k == first_s + 5)  col = 4'b0011;
        if (r.corrupt && first_s >= 0 && k == first_s + 21) col = 4'b0000;
        if (r.interfere && first_s >= 0 && k == first_s + 10) begin
          press    = 1'b1;
          key_code = 4'b0101;
        end
        #1;
      end
      if (first_s < 0 && col == 4'b0001 && col_prev != 4'b0001) first_s = k;
      if (r.corrupt && first_s >= 0 && (k == first_s + 5 || k == first_s + 21))
        check({tag, "_fila_corrupt_col"}, fila_a, 0);
      if (fila_a != 4'b0000) hits++;
      if (fila_a != 4'b0000 && (fila_a != r.exp_fila || col != r.exp_col)) bad++;
      if (error_a) errs++;
      if (done_a) begin
        done_k = k;
        check({tag, "_busy_at_done"}, busy_a, 0);
        break;
      end
      if (!busy_a) busy_gap++;
    end
    check({tag, "_done_seen"}, (done_k >= 0) ? 1 : 0, 1);
    check({tag, "_done_latency"}, done_k - first_s, 97);
    check({tag, "_fila_hits"}, hits, r.exp_hits);
    check({tag, "_fila_wrong"}, bad, 0);
    check({tag, "_error_pulses"}, errs, 0);
    check({tag, "_busy_gap"}, busy_gap, 0);
    for (int k = 0; k < 40; k++) begin
      step();
      #1;
      if (done_a) late_done++;
      if (busy_a) late_busy++;
    end
    check({tag, "_extra_done"}, late_done, 0);
    check({tag, "_busy_after"}, late_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t tbl[7];
    int eb_k, ea_k, eb_n, ea_n, dn, busy31, found;

    tbl[0] = '{4'b0001, 4'b0001, 4'b0010, 16, 1'b0, 1'b0};
    tbl[1] = '{4'b1011, 4'b0100, 4'b1000, 16, 1'b0, 1'b0};
    tbl[2] = '{4'b0000, 4'b0001, 4'b0001, 16, 1'b0, 1'b0};
    tbl[3] = '{4'b0110, 4'b0010, 4'b0100, 16, 1'b0, 1'b0};
    tbl[4] = '{4'b1111, 4'b1000, 4'b1000, 16, 1'b0, 1'b0};
    tbl[5] = '{4'b0001, 4'b0001, 4'b0010, 14, 1'b1, 1'b0};
    tbl[6] = '{4'b1011, 4'b0100, 4'b1000, 16, 1'b0, 1'b1};

    reset    = 1'b1;
    key_code = 4'b0000;
    press    = 1'b0;
    col      = 4'b0001;
    for (int i = 0; i < 5; i++) step();
    #1;
    check("reset_fila", fila_a, 0);
    check("reset_busy", busy_a, 0);
    check("reset_done", done_a, 0);
    check("reset_error", error_a, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    #1;
    check("idle_busy", busy_a, 0);
    check("idle_fila", fila_a, 0);

    foreach (tbl[i]) run_request(tbl[i], $sformatf("req%0d", i));

    // Frozen column: no scan start ever comes, both instances must abort.
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) step();
    key_code = 4'b0001;
    press    = 1'b1;
    step();
    press = 1'b0;
    #1;
    eb_k = -1; ea_k = -1; eb_n = 0; ea_n = 0; dn = 0; busy31 = 0;
    for (int k = 0; k < 1100; k++) begin
      if (k > 0) begin
        step();
        #1;
      end
      if (k == 31) busy31 = busy_b;
      if (error_b) begin
        eb_n++;
        if (eb_k < 0) begin
          eb_k = k;
          check("to32_busy_at_error", busy_b, 0);
        end
      end
      if (error_a) begin
        ea_n++;
        if (ea_k < 0) begin
          ea_k = k;
          check("to1024_busy_at_error", busy_a, 0);
        end
      end
      if (done_a || done_b) dn++;
      if (fila_a != 4'b0000 || fila_b != 4'b0000) dn++;
    end
    check("to32_busy_before", busy31, 1);
    check("to32_error_cycle", eb_k, 32);
    check("to32_error_width", eb_n, 1);
    check("to1024_error_cycle", ea_k, 1024);
    check("to1024_error_width", ea_n, 1);
    check("to_no_done_or_fila", dn, 0);
    freeze = 1'b0;
    for (int i = 0; i < 20; i++) step();

    // Asynchronous reset while the key is being answered.
    key_code = 4'b0001;
    press    = 1'b1;
    step();
    press = 1'b0;
    #1;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      if (fila_a != 4'b0000) begin
        found = 1;
        break;
      end
      step();
      #1;
    end
    check("rst_fila_seen", found, 1);
    #1;
    reset = 1'b1;
    #1;
    check("rst_async_fila", fila_a, 0);
    check("rst_async_busy", busy_a, 0);
    check("rst_async_done", done_a, 0);
    check("rst_async_error", error_a, 0);
    step();
    step();
    reset = 1'b0;
    step();
    #1;
    check("rst_after_busy", busy_a, 0);
    run_request(tbl[0], "post_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
